// File: rtl/xosera_pkg.sv
// Shared primitive-renderer definitions: opcodes and command-queue state.
// Referenced as xv:: by the renderer and the command queue.
package xv;

   localparam logic [3:0] PR_COORDX0 = 4'h0;
   localparam logic [3:0] PR_COORDY0 = 4'h1;
   localparam logic [3:0] PR_COORDX1 = 4'h2;
   localparam logic [3:0] PR_COORDY1 = 4'h3;
   localparam logic [3:0] PR_COORDX2 = 4'h4;
   localparam logic [3:0] PR_COORDY2 = 4'h5;
   localparam logic [3:0] PR_COLOR   = 4'h6;
   localparam logic [3:0] PR_EXECUTE = 4'hF;

   typedef enum logic [1:0] {
      PQ_READY,
      PQ_WAIT_START,
      PQ_WAIT_DONE
   } prim_q_state_t;

   function automatic logic is_execute(input logic [15:0] cmd);
      return cmd[15:12] == PR_EXECUTE;
   endfunction

endpackage

// File: rtl/prim_cmd_fifo.sv
// Command FIFO for prim_cmd_queue: storage, wrapping pointers, level count.
// The caller decides acceptance; push/pop here are always honoured.
module prim_cmd_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 16
) (
   input  logic                       clk,
   input  logic                       reset_i,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   // storage write; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= wdata;
      end
   end

   // pointers wrap naturally at DEPTH; level kept as a separate count
   always_ff @(posedge clk) begin
      if (reset_i) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)
            level <= level + 1'b1;
         else if (pop && !push)
            level <= level - 1'b1;
      end
   end

   assign rdata = mem[rptr];
   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);

endmodule

// File: rtl/prim_cmd_queue.sv
// Command queue feeding the primitive renderer, fenced around PR_EXECUTE.
// Optional sticky overflow flag built when PRIM_CMD_OVERFLOW_EN is defined.
module prim_cmd_queue
   import xv::*;
#(
   parameter int DEPTH         = 16,
   parameter int START_TIMEOUT = 7
) (
   input  logic                       clk,
   input  logic                       reset_i,
   input  logic                       cmd_wr_i,
   input  logic [15:0]                cmd_data_i,
   output logic [15:0]                cmd_o,
   output logic                       cmd_valid_o,
   input  logic                       prim_busy_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       idle_o,
   output logic                       overflow_o,
   input  logic                       ovf_clear_i
);

   localparam logic [3:0] TIMEOUT = 4'(START_TIMEOUT);

   prim_q_state_t state;
   prim_q_state_t state_n;
   logic [3:0]    cnt;
   logic [3:0]    cnt_n;
   logic          pop;
   logic          push;
   logic          drop;
   logic [15:0]   head;

   // a full queue still accepts when the head leaves in the same cycle
   assign push = cmd_wr_i && (!full_o || pop);
   assign drop = cmd_wr_i && !push;

   prim_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (16)
   ) u_fifo (
      .clk     (clk),
      .reset_i (reset_i),
      .push    (push),
      .pop     (pop),
      .wdata   (cmd_data_i),
      .rdata   (head),
      .full    (full_o),
      .empty   (empty_o),
      .level   (level_o)
   );

   // fence FSM: next state, pop decision and start-timeout count
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pop     = 1'b0;
      unique case (state)
         PQ_READY: begin
            if (!empty_o && !prim_busy_i) begin
               pop = 1'b1;
               if (is_execute(head)) begin
                  state_n = PQ_WAIT_START;
                  cnt_n   = '0;
               end
            end
         end
         PQ_WAIT_START: begin
            if (prim_busy_i)
               state_n = PQ_WAIT_DONE;
            else if (cnt + 4'd1 == TIMEOUT)
               state_n = PQ_READY;
            else
               cnt_n = cnt + 4'd1;
         end
         PQ_WAIT_DONE: begin
            if (!prim_busy_i)
               state_n = PQ_READY;
         end
         default: state_n = PQ_READY;
      endcase
   end

   // state register plus registered issue port
   always_ff @(posedge clk) begin
      if (reset_i) begin
         state       <= PQ_READY;
         cnt         <= '0;
         cmd_o       <= '0;
         cmd_valid_o <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         cmd_valid_o <= pop;
         if (pop)
            cmd_o <= head;
      end
   end

   assign idle_o = empty_o && (state == PQ_READY) && !prim_busy_i;

`ifdef PRIM_CMD_OVERFLOW_EN
   // sticky overflow; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk) begin
      if (reset_i)
         overflow_o <= 1'b0;
      else if (drop)
         overflow_o <= 1'b1;
      else if (ovf_clear_i)
         overflow_o <= 1'b0;
   end
`else
   logic unused_ovf;
   assign unused_ovf = &{1'b0, drop, ovf_clear_i};
   assign overflow_o = 1'b0;
`endif

endmodule

// File: doc/prim_cmd_queue.md
# prim_cmd_queue

Command queue sitting directly upstream of the primitive renderer. Accepts 16-bit primitive commands from the register interface, buffers them in a FIFO, and issues them one at a time on the renderer's `cmd_i`/`cmd_valid_i` port. Issue is fenced around `PR_EXECUTE`: no further command is released until the triangle has started and `busy_o` has fallen again. The CPU can therefore stream a whole triangle list without polling.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `START_TIMEOUT`, 7: cycles to wait for renderer busy to rise after an execute; range 1–15.
- `clk` in 1: system clock.
- `reset_i` in 1: reset; one clock, synchronous, active-high.
- `cmd_wr_i` in 1: write strobe, one entry per cycle high.
- `cmd_data_i` in 16: command word; bits [15:12] opcode, [11:0] operand.
- `cmd_o` out 16: command to renderer.
- `cmd_valid_o` out 1: one-cycle issue strobe.
- `prim_busy_i` in 1: renderer `busy_o`.
- `full_o` out 1: level == DEPTH.
- `empty_o` out 1: level == 0.
- `level_o` out $clog2(DEPTH+1): entries held.
- `idle_o` out 1: queue empty, state READY, `prim_busy_i` low.
- `overflow_o` out 1: sticky, a write was dropped.
- `ovf_clear_i` in 1: clears `overflow_o`.

## Operation
- FIFO uses read/write pointers of $clog2(DEPTH) bits; they wrap naturally. Level is tracked in a separate counter.
- **Write:** accepted when not full, or when a pop occurs in the same cycle. `full_o` is evaluated on the pre-edge level. Otherwise the write is dropped and overflow is set. Contents and level are unchanged on a drop.
- **States:**
  - READY: pop when not empty and `prim_busy_i` low. The popped word is registered to `cmd_o` and `cmd_valid_o` is high for one cycle. If the opcode is `PR_EXECUTE`, go to WAIT_START; otherwise stay in READY.
  - WAIT_START: counter cleared on entry. On `prim_busy_i` high, go to WAIT_DONE. If the counter reaches START_TIMEOUT, go to READY; this covers degenerate triangles that never raise busy. No pops in this state.
  - WAIT_DONE: on `prim_busy_i` low, go to READY. No pops in this state.
- Non-execute commands are also held while `prim_busy_i` is high. Coordinates are never altered during a draw.
- `cmd_o` holds its last value between strobes.
- **Reset:** resets the whole block, including mid-operation. Pointers, level and state go to READY. All queued entries are discarded. Outputs after reset: `cmd_o`=0, `cmd_valid_o`=0, `empty_o`=1, `full_o`=0, `level_o`=0, `overflow_o`=0, `idle_o` follows `prim_busy_i`.

## Timing
- Write sampled at edge E into an empty queue in READY with busy low:
  - `level_o`=1 after E;
  - pop at E+1, so `cmd_valid_o` is high in the cycle after E+1;
  - `level_o` returns to 0 after E+1.
- Back-to-back non-execute commands issue at one per cycle.
- After an execute strobe at edge P, the next pop is no earlier than the edge after `prim_busy_i` is sampled low in WAIT_DONE. On the timeout path, it is no earlier than P+START_TIMEOUT+1.
- Simultaneous write and pop: level unchanged, both take effect.
- Simultaneous `ovf_clear_i` and an overflow event: set wins.

## Configuration
- `PRIM_CMD_OVERFLOW_EN` defined: sticky overflow register and clear logic are built.
- Undefined: `overflow_o` is tied 0 and `ovf_clear_i` is ignored. Writes when full are still dropped.

## Structure
- Opcode constants (`PR_EXECUTE` and the other `PR_*` values) stay in `xosera_pkg` as `xv::`. The queue state enum `prim_q_state_t` is added there.
- One natural sub-module, `prim_cmd_fifo`: storage, pointers, level, full/empty. The parent owns the fence FSM, timeout counter and overflow flag.

## Test plan
- **Simple issue:** write 0x0010, 0x1020, 0x2030 on consecutive cycles with busy low → three consecutive `cmd_valid_o` strobes carrying those words, first strobe 2 cycles after the first write, `level_o` back to 0.
- **Fence:** write a coordinate, `PR_EXECUTE`, then `PR_COLOR`. Busy rises 2 cycles after the execute strobe and stays high 20 cycles → `PR_COLOR` issues only after busy falls; no strobe while busy is high.
- **Timeout:** execute with busy held low → next command issues exactly START_TIMEOUT+1 cycles after the execute strobe.
- **Overflow:** busy held high, write DEPTH+2 words → `full_o`=1, `level_o`=DEPTH, `overflow_o`=1. After busy drops, exactly the first DEPTH words issue in order. Pulse `ovf_clear_i` → `overflow_o`=0. Repeat with the macro undefined → `overflow_o` stays 0.
- **Full with simultaneous pop:** fill to DEPTH, drop busy, write on the pop cycle → write accepted, no overflow.
- **Reset mid-fence:** reset asserted in WAIT_DONE with 5 entries queued → after one cycle `empty_o`=1, `level_o`=0, `cmd_valid_o`=0, state READY; a new write issues normally.
